// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU program sequencer: opcodes, instruction layout and FSM states.
package alu_seq_pkg;

    localparam int INSTR_W = 19;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        SHL = 3'b010,
        SHR = 3'b011,
        AND = 3'b100,
        OR  = 3'b101,
        XOR = 3'b110,
        NOT = 3'b111
    } opcode_t;

    typedef struct packed {
        opcode_t           op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_pc.sv
// Program counter for the sequencer: loads the run's first address, increments and wraps
// modulo 2**ADDR_W, and flags the last address of the run.
module alu_seq_pc #(
    parameter int ADDR_W     = 6,
    parameter int PROG_LEN   = 64,
    parameter int START_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic              is_last
);

    localparam int                LAST_INT = (START_ADDR + PROG_LEN - 1) % (2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_INT);

    // Load wins over increment so an abort during a handshake rewinds the run.
    always_ff @(posedge clock) begin
        if (reset || load) begin
            pc <= FIRST;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

    assign is_last = (pc == LAST);

endmodule

// File: rtl/alu_program_sequencer.sv
// Fetches PROG_LEN instructions from a combinational ROM, runs each through the external ALU
// and presents results on a valid/ready port. Define ALU_FLAGS_EN to add res_zero/res_neg.
module alu_program_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int PROG_LEN   = 64,
    parameter int START_ADDR = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [2:0]         alu_sel,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic [DATA_W-1:0]  res_data,
    output logic [2:0]         res_op,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
`ifdef ALU_FLAGS_EN
    output logic               res_zero,
    output logic               res_neg,
`endif
    output logic               done,
    output state_t             state_dbg
);

    // Result port: a transfer happens on any rising edge with res_valid && res_ready;
    // res_valid, res_data and res_op stay frozen until then, and res_valid never drops
    // without a transfer except on abort or reset.
    state_t            state;
    instr_t            instr;
    logic [ADDR_W-1:0] pc;
    logic              is_last;
    logic              handshake;
    logic              kill;
    logic              pc_load;
    logic              pc_inc;

    assign handshake = res_valid && res_ready;
    assign kill      = abort && (state != IDLE);
    assign pc_load   = kill || (state == DONE);
    assign pc_inc    = (state == OUT) && handshake && !is_last;

    alu_seq_pc #(
        .ADDR_W    (ADDR_W),
        .PROG_LEN  (PROG_LEN),
        .START_ADDR(START_ADDR)
    ) u_pc (
        .clock  (clock),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .pc     (pc),
        .is_last(is_last)
    );

    assign rom_addr  = pc;
    assign alu_sel   = instr.op;
    assign alu_a     = instr.a;
    assign alu_b     = instr.b;
    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            instr     <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ALU_FLAGS_EN
            res_zero  <= 1'b0;
            res_neg   <= 1'b0;
`endif
        end else if (kill) begin
            // A result in flight is treated as consumed; no done pulse.
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    instr <= instr_t'(rom_data);
                    state <= EXEC;
                end
                EXEC: begin
                    res_data  <= alu_result;
                    res_op    <= instr.op;
                    res_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
                    res_zero  <= (alu_result == '0);
                    res_neg   <= alu_result[DATA_W-1];
`endif
                    state     <= OUT;
                end
                OUT: begin
                    if (handshake) begin
                        res_valid <= 1'b0;
                        if (is_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
